// File: rtl/elastic_buf.sv
// Elastic buffer: DEPTH-entry show-ahead FIFO with a valid/ready handshake on both sides.
// It also reports occupancy and has a synchronous flush. All status outputs come from the registered count.
module elastic_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  generate
    if (DATA_W < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_chk
      $error("elastic_buf: DATA_W must be >=1 and DEPTH a power of two >=2");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Stored words are masked to zero when empty, so a stale entry is never exposed after a flush.
  assign data_out  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (reset) count <= CNT_W'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) full |-> !push);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) empty |-> !pop);

endmodule

// File: tb/tb_elastic_buf.sv
// Bench for elastic_buf: three configurations share one stimulus stream; a queue model per
// configuration holds the expected contents, and a negedge monitor compares every output against it.
module tb_elastic_buf;

  logic        clk = 0;
  logic        reset = 1;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic [63:0] din = '0;

  always #5 clk = ~clk;

  logic [31:0] d0; logic [2:0] c0; logic r0, v0, f0, e0;
  logic [7:0]  d1; logic [1:0] c1; logic r1, v1, f1, e1;
  logic [63:0] d2; logic [4:0] c2; logic r2, v2, f2, e2;

  elastic_buf #(.DATA_W(32), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r0),
    .data_in(din[31:0]), .out_valid(v0), .out_ready(out_ready), .data_out(d0),
    .count(c0), .full(f0), .empty(e0));

  elastic_buf #(.DATA_W(8), .DEPTH(2)) u_small (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r1),
    .data_in(din[7:0]), .out_valid(v1), .out_ready(out_ready), .data_out(d1),
    .count(c1), .full(f1), .empty(e1));

  elastic_buf #(.DATA_W(64), .DEPTH(16)) u_big (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r2),
    .data_in(din), .out_valid(v2), .out_ready(out_ready), .data_out(d2),
    .count(c2), .full(f2), .empty(e2));

  logic [63:0] odat [3];
  int          ocnt [3];
  logic        ordy [3], ovld [3], ofull [3], oemp [3];

  assign odat[0] = {32'b0, d0}; assign ocnt[0] = 32'(c0);
  assign odat[1] = {56'b0, d1}; assign ocnt[1] = 32'(c1);
  assign odat[2] = d2;          assign ocnt[2] = 32'(c2);
  assign ordy[0] = r0; assign ovld[0] = v0; assign ofull[0] = f0; assign oemp[0] = e0;
  assign ordy[1] = r1; assign ovld[1] = v1; assign ofull[1] = f1; assign oemp[1] = e1;
  assign ordy[2] = r2; assign ovld[2] = v2; assign ofull[2] = f2; assign oemp[2] = e2;

  int          dep [3] = '{4, 2, 16};
  logic [63:0] msk [3] = '{64'hFFFF_FFFF, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] q [3][$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue per configuration, updated from the handshake rules.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset || flush) begin
        q[i].delete();
      end else begin
        automatic bit pu = in_valid && (q[i].size() < dep[i]);
        automatic bit po = out_ready && (q[i].size() > 0);
        if (po) void'(q[i].pop_front());
        if (pu) q[i].push_back(din & msk[i]);
      end
    end
  end

  // Monitor: compares each configuration's outputs to the model contents, away from the clock edge.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        automatic int n = q[i].size();
        automatic logic [63:0] exp_d = (n > 0) ? q[i][0] : 64'h0;
        chk($sformatf("count[%0d]", i), 64'(ocnt[i]), 64'(n));
        chk($sformatf("full[%0d]", i), 64'(ofull[i]), 64'(n == dep[i]));
        chk($sformatf("empty[%0d]", i), 64'(oemp[i]), 64'(n == 0));
        chk($sformatf("in_ready[%0d]", i), 64'(ordy[i]), 64'(n < dep[i]));
        chk($sformatf("out_valid[%0d]", i), 64'(ovld[i]), 64'(n > 0));
        chk($sformatf("data_out[%0d]", i), odat[i], exp_d);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset state, then fill to full; the fifth word must be refused.
    chk("rst_out_valid", 64'(v0), 64'd0);
    chk("rst_in_ready", 64'(r0), 64'd1);
    chk("rst_count", 64'(c0), 64'd0);
    chk("rst_data_out", 64'(d0), 64'd0);
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      din = 64'(32'hA000_0001 + k);
      cyc();
    end
    chk("fill_count", 64'(c0), 64'd4);
    chk("fill_full", 64'(f0), 64'd1);
    chk("fill_in_ready", 64'(r0), 64'd0);
    din = 64'hDEAD_BEEF;
    cyc();
    chk("over_count", 64'(c0), 64'd4);

    // Drain in order.
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_data", 64'(d0), 64'(32'hA000_0001 + k));
      cyc();
    end
    chk("drain_empty", 64'(e0), 64'd1);
    chk("drain_out_valid", 64'(v0), 64'd0);
    chk("drain_data_zero", 64'(d0), 64'd0);

    // Streaming across several pointer wraps.
    in_valid = 1; out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      din = 64'(k);
      cyc();
    end
    chk("stream_count", 64'(c0), 64'd1);
    chk("stream_last", 64'(d0), 64'd19);

    // Full with a simultaneous pop: pop happens, push is refused.
    in_valid = 0;
    repeat (20) cyc();
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      din = 64'(32'hB000_0000 + k);
      cyc();
    end
    chk("full2_count", 64'(c0), 64'd4);
    out_ready = 1; din = 64'hB000_0010;
    cyc();
    chk("fullpop_count", 64'(c0), 64'd3);
    chk("fullpop_head", 64'(d0), 64'hB000_0001);
    cyc();
    chk("fullpop_next_count", 64'(c0), 64'd3);

    // Flush beats a simultaneous push and pop.
    flush = 1; din = 64'hC0C0;
    cyc();
    flush = 0;
    chk("flush_count", 64'(c0), 64'd0);
    chk("flush_empty", 64'(e0), 64'd1);
    chk("flush_data", 64'(d0), 64'd0);
    out_ready = 0; din = 64'h55;
    cyc();
    chk("post_flush_data", 64'(d0), 64'h55);
    chk("post_flush_count", 64'(c0), 64'd1);

    // Asynchronous reset mid-stream at count=2.
    din = 64'h66;
    cyc();
    in_valid = 0;
    chk("pre_rst_count", 64'(c0), 64'd2);
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("arst_count", 64'(c0), 64'd0);
    chk("arst_out_valid", 64'(v0), 64'd0);
    chk("arst_in_ready", 64'(r0), 64'd1);
    chk("arst_data", 64'(d0), 64'd0);
    @(posedge clk);
    #3 reset = 0;
    in_valid = 1; din = 64'h77;
    cyc();
    in_valid = 0;
    chk("after_rst_data", 64'(d0), 64'h77);
    chk("after_rst_count", 64'(c0), 64'd1);

    // Randomized traffic: producer-heavy, then consumer-heavy, with rare flushes.
    for (int k = 0; k < 1500; k++) begin
      automatic int pin  = (k < 750) ? 80 : 35;
      automatic int pout = (k < 750) ? 35 : 80;
      in_valid  = ($urandom_range(99) < pin);
      out_ready = ($urandom_range(99) < pout);
      flush     = ($urandom_range(99) < 2);
      din       = {$urandom, $urandom};
      cyc();
    end
    in_valid = 0; out_ready = 0; flush = 0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
